vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM (256-colour, 8-bit pixels, 20-bit {y,x} address) between the VGA scanout path and a CPU port.
- Scanout has absolute priority during the visible area.
- CPU writes are buffered in a small FIFO and drained whenever scanout is idle.
- CPU reads are single-outstanding and ordered after all earlier writes.

Parameters:
- ADDR_W, 20, RAM address width ({pixel_y[9:0], pixel_x[9:0]}).
- DATA_W, 8, pixel / RAM data width.
- FIFO_DEPTH, 4, CPU write FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, asynchronous, active-high.
- vga_en  in  1  scanout owns the RAM this cycle (video enable).
- vga_addr  in  ADDR_W  scanout pixel address.
- vga_data  out  DATA_W  registered pixel data to the VGA colour registers.
- cpu_req  in  1  CPU request valid.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ready  out  1  request accepted when cpu_req && cpu_ready.
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata is valid.
- cpu_rdata  out  DATA_W  read data.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after the address is presented.

Behaviour:

Reset:
- While rst=1: state=IDLE, FIFO empty, vga_data=0, cpu_rvalid=0, cpu_rdata=0, mem_we=0, cpu_ready=0.
- The first cycle after reset release: cpu_ready=1.
- Asserting rst mid-operation discards FIFO contents and any pending read. No rvalid is produced for a discarded read.

Grant (combinational, evaluated each cycle in priority order):
- G_VGA if vga_en: mem_addr=vga_addr, mem_we=0.
- Else G_WR if FIFO not empty: mem_addr/mem_wdata = FIFO head, mem_we=1, pop.
- Else G_RD if state=RD_PEND: mem_addr = held read address, mem_we=0.
- Else G_NONE: mem_we=0, mem_addr=vga_addr.

Scanout path:
- vga_data is registered from mem_rdata when the grant two cycles earlier was G_VGA; otherwise it is 0.
- Fixed latency: vga_addr at cycle N -> vga_data at cycle N+2.

CPU handshake:
- cpu_ready = (state==IDLE) && !fifo_full, computed from registered state only. No same-cycle pass-through, even when a pop occurs.
- Write accept (cpu_req && cpu_we && cpu_ready): push {addr, wdata}. The earliest RAM write is in the next cycle.
- Read accept (cpu_req && !cpu_we && cpu_ready): latch the address; IDLE -> RD_PEND.

State machine:
- IDLE: as above.
- RD_PEND: waits for G_RD. A read issues only once the FIFO is empty, which preserves read-after-write ordering. On G_RD -> RD_DATA.
- RD_DATA (1 cycle): capture mem_rdata into cpu_rdata; -> IDLE.
- cpu_rvalid=1 in the cycle after RD_DATA. That is, issue at cycle N -> rvalid at N+2, and cpu_ready returns at N+2.

Other rules:
- Writes during RD_PEND/RD_DATA are not accepted (cpu_ready=0).
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
- full is asserted when the pointers are equal except for the MSB; empty is asserted when the pointers are fully equal.
- Push and pop in the same cycle keep the count unchanged.
- A CPU request during continuous vga_en is held indefinitely; no starvation guard exists. Writes drain during blanking.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- Defined: adds output stall_cnt (16 bits) and input stall_clr (1 bit).
  - stall_cnt increments by 1 each cycle where (FIFO not empty || state==RD_PEND) && vga_en.
  - stall_cnt saturates at 16'hFFFF.
  - stall_cnt clears to 0 on rst or on stall_clr=1. stall_clr has priority over increment.
- Undefined: the ports and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset then vga_en=1, vga_addr=20'h00005, mem_rdata=8'hA5 one cycle later -> vga_data=8'hA5 exactly 2 cycles after the address; vga_data=0 when vga_en=0.
- vga_en=0; write addr 20'h00010 data 8'h3C -> mem_we=1, mem_addr=20'h00010, mem_wdata=8'h3C in the next cycle; cpu_ready stays 1.
- vga_en=1 held; 4 back-to-back writes -> all accepted; 5th sees cpu_ready=0 and mem_we stays 0. Drop vga_en -> 4 writes issue in push order on consecutive cycles, then cpu_ready=1.
- FIFO holds 2 writes, vga_en=0; read 20'h00010 -> both writes issue first, then the read. cpu_rvalid pulses once with the data just written (8'h3C); cpu_ready=0 until that rvalid.
- Read pending under vga_en=1 for 10 cycles -> no rvalid. vga_en falls -> read issues, rvalid 2 cycles later. With VRAM_ARB_STATS_EN defined: stall_cnt=10; stall_clr -> 0.
- Assert rst with 3 FIFO entries and a read pending -> mem_we=0 thereafter, no rvalid; after release the FIFO is empty and cpu_ready=1.

Source files
------------

// File: rtl/vram_arbiter.sv
// Framebuffer RAM arbiter: scanout has priority, CPU writes are buffered in a FIFO, CPU reads are single-outstanding.
// Optional stall statistics counter is enabled with `define VRAM_ARB_STATS_EN.
module vram_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_en,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
    ,
    input  logic              stall_clr,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, RD_PEND, RD_DATA} state_t;
    typedef enum logic [1:0] {G_NONE, G_VGA, G_WR, G_RD} grant_t;

    state_t              r_state;
    state_t              w_nextState;
    grant_t              w_grant;
    logic [PTR_W-1:0]    r_wrPtr;
    logic [PTR_W-1:0]    r_rdPtr;
    logic [ADDR_W-1:0]   r_fifoAddr [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_fifoData [FIFO_DEPTH];
    logic [ADDR_W-1:0]   r_rdAddr;
    logic                r_vgaPipe;
    logic [DATA_W-1:0]   r_vgaData;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rvalid;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_rdAccept;
    logic [IDX_W-1:0]    w_wrIdx;
    logic [IDX_W-1:0]    w_rdIdx;

    assign w_wrIdx    = r_wrPtr[IDX_W-1:0];
    assign w_rdIdx    = r_rdPtr[IDX_W-1:0];
    assign w_empty    = (r_wrPtr == r_rdPtr);
    assign w_full     = (r_wrPtr[PTR_W-1] != r_rdPtr[PTR_W-1]) && (w_wrIdx == w_rdIdx);
    // Ready depends only on registered state, so a pop never frees a slot in the same cycle.
    assign cpu_ready  = !rst && (r_state == IDLE) && !w_full;
    assign w_push     = cpu_req && cpu_we && cpu_ready;
    assign w_rdAccept = cpu_req && !cpu_we && cpu_ready;
    assign w_pop      = (w_grant == G_WR);

    assign vga_data   = r_vgaData;
    assign cpu_rdata  = r_rdata;
    assign cpu_rvalid = r_rvalid;

    // A read only issues once the FIFO has drained, keeping reads behind earlier writes.
    always_comb begin
        w_grant   = G_NONE;
        mem_addr  = vga_addr;
        mem_we    = 1'b0;
        mem_wdata = r_fifoData[w_rdIdx];
        if (vga_en) begin
            w_grant = G_VGA;
        end else if (!w_empty) begin
            w_grant  = G_WR;
            mem_addr = r_fifoAddr[w_rdIdx];
            mem_we   = 1'b1;
        end else if (r_state == RD_PEND) begin
            w_grant  = G_RD;
            mem_addr = r_rdAddr;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_rdAccept) w_nextState = RD_PEND;
            RD_PEND: if (w_grant == G_RD) w_nextState = RD_DATA;
            RD_DATA: w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_rdAddr <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
            if (w_rdAccept) r_rdAddr <= cpu_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoAddr[w_wrIdx] <= cpu_addr;
            r_fifoData[w_wrIdx] <= cpu_wdata;
        end
    end

    // RAM data arrives one cycle after the address, so the pixel lands two cycles after the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vgaPipe <= 1'b0;
            r_vgaData <= '0;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
        end else begin
            r_vgaPipe <= (w_grant == G_VGA);
            r_vgaData <= r_vgaPipe ? mem_rdata : '0;
            r_rvalid  <= (r_state == RD_DATA);
            if (r_state == RD_DATA) r_rdata <= mem_rdata;
        end
    end

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] r_stallCnt;
    assign stall_cnt = r_stallCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if (stall_clr) begin
            r_stallCnt <= '0;
        end else if ((!w_empty || r_state == RD_PEND) && vga_en && r_stallCnt != 16'hFFFF) begin
            r_stallCnt <= r_stallCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_vram_arbiter;

    localparam int AW    = 20;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vga_en = 1'b0;
    logic [AW-1:0] vga_addr = '0;
    logic [DW-1:0] vga_data;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ready;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef VRAM_ARB_STATS_EN
    logic          stall_clr = 1'b0;
    logic [15:0]   stall_cnt;
`endif

    int checkCnt = 0;
    int passCnt  = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .vga_en(vga_en), .vga_addr(vga_addr), .vga_data(vga_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef VRAM_ARB_STATS_EN
        , .stall_clr(stall_clr), .stall_cnt(stall_cnt)
`endif
    );

    function automatic logic [7:0] pattern(int i);
        return 8'(i) ^ 8'hA0 ^ 8'(i >> 8);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        if (obs === exp) passCnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // One call per clock cycle; inputs change just after the rising edge.
    task automatic applyStimulus(input bit en, input logic [AW-1:0] vaddr, input bit req, input bit we,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input bit clr);
        @(posedge clk);
        #1;
        vga_en    = en;
        vga_addr  = vaddr;
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
`ifdef VRAM_ARB_STATS_EN
        stall_clr = clr;
`else
        if (clr) begin end
`endif
    endtask

    // Synchronous RAM with registered read data, reloaded with a known pattern on reset.
    logic [7:0] ram [4096];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) ram[i] <= pattern(i);
        end else begin
            if (mem_we) ram[mem_addr[11:0]] <= mem_wdata;
            mem_rdata <= ram[mem_addr[11:0]];
        end
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    // Reference model: pending writes as a queue, RAM contents as the bus sees them,
    // and the CPU's view where every accepted write is already visible.
    wr_t        q[$];
    wr_t        w;
    logic [7:0] golden  [4096];
    logic [7:0] cpuView [4096];
    bit         rdBusy, rdPend, expRv, expReady, gWr, gRd;
    logic [AW-1:0] rdAddr, expAddr;
    logic [DW-1:0] rdExp, vNow, vNext, newV;
    logic [15:0]   stallExp;
    int         cyc = 0;
    int         rvAt = -1;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            rdBusy = 0; rdPend = 0; rvAt = -1;
            vNow = '0; vNext = '0; stallExp = '0;
            for (int i = 0; i < 4096; i++) begin
                golden[i]  = pattern(i);
                cpuView[i] = pattern(i);
            end
            checkOutput("rst_ready",  32'(cpu_ready),  32'd0);
            checkOutput("rst_mem_we", 32'(mem_we),     32'd0);
            checkOutput("rst_rvalid", 32'(cpu_rvalid), 32'd0);
            checkOutput("rst_rdata",  32'(cpu_rdata),  32'd0);
            checkOutput("rst_vga",    32'(vga_data),   32'd0);
        end else begin
            cyc++;
            expRv = (rvAt == cyc);
            if (expRv) rdBusy = 0;
            expReady = !rdBusy && (q.size() < DEPTH);
            checkOutput("cpu_ready",  32'(cpu_ready),  32'(expReady));
            checkOutput("cpu_rvalid", 32'(cpu_rvalid), 32'(expRv));
            if (expRv) checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(rdExp));
            checkOutput("vga_data", 32'(vga_data), 32'(vNow));

            gWr = !vga_en && (q.size() > 0);
            gRd = !vga_en && (q.size() == 0) && rdPend;
            expAddr = gWr ? q[0].addr : (gRd ? rdAddr : vga_addr);
            checkOutput("mem_we",   32'(mem_we),   32'(gWr));
            checkOutput("mem_addr", 32'(mem_addr), 32'(expAddr));
            if (gWr) checkOutput("mem_wdata", 32'(mem_wdata), 32'(q[0].data));

`ifdef VRAM_ARB_STATS_EN
            checkOutput("stall_cnt", 32'(stall_cnt), 32'(stallExp));
            if (stall_clr) stallExp = '0;
            else if ((q.size() > 0 || rdPend) && vga_en && stallExp != 16'hFFFF) stallExp = stallExp + 16'd1;
`endif

            newV = vga_en ? golden[vga_addr[11:0]] : 8'h00;
            if (gWr) begin
                golden[q[0].addr[11:0]] = q[0].data;
                void'(q.pop_front());
            end
            if (gRd) begin
                rdPend = 0;
                rvAt   = cyc + 2;
            end
            if (cpu_req && expReady) begin
                if (cpu_we) begin
                    w.addr = cpu_addr;
                    w.data = cpu_wdata;
                    q.push_back(w);
                    cpuView[cpu_addr[11:0]] = cpu_wdata;
                end else begin
                    rdBusy = 1;
                    rdPend = 1;
                    rdAddr = cpu_addr;
                    rdExp  = cpuView[cpu_addr[11:0]];
                end
            end
            vNow  = vNext;
            vNext = newV;
        end
    end

    task automatic waitRead(input string tag, input logic [DW-1:0] expData);
        bit seen;
        seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            applyStimulus(0, '0, 0, 0, '0, '0, 0);
            @(negedge clk);
            if (cpu_rvalid) begin
                seen = 1;
                checkOutput(tag, 32'(cpu_rdata), 32'(expData));
            end
        end
        checkOutput({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    bit enState;

    initial begin
        $display("[TB] start");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", 32'(cpu_ready), 32'd1);

        // Scanout latency: pattern(5) = 8'hA5
        applyStimulus(1, 20'h00005, 0, 0, '0, '0, 0);
        applyStimulus(0, 20'h00000, 0, 0, '0, '0, 0);
        applyStimulus(0, 20'h00000, 0, 0, '0, '0, 0);
        @(negedge clk);
        checkOutput("vga_lat2", 32'(vga_data), 32'h0A5);
        applyStimulus(0, 20'h00000, 0, 0, '0, '0, 0);
        @(negedge clk);
        checkOutput("vga_off", 32'(vga_data), 32'd0);

        // Single write in blanking
        applyStimulus(0, '0, 1, 1, 20'h00010, 8'h3C, 0);
        applyStimulus(0, '0, 0, 0, '0, '0, 0);
        @(negedge clk);
        checkOutput("wr_we",    32'(mem_we),    32'd1);
        checkOutput("wr_addr",  32'(mem_addr),  32'h10);
        checkOutput("wr_data",  32'(mem_wdata), 32'h3C);
        checkOutput("wr_ready", 32'(cpu_ready), 32'd1);

        // Fill FIFO under scanout, fifth write refused
        applyStimulus(1, '0, 0, 0, '0, '0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, '0, 1, 1, 20'(32'h20 + i), 8'(8'h40 + i), 0);
        applyStimulus(1, '0, 1, 1, 20'h00024, 8'h44, 0);
        @(negedge clk);
        checkOutput("full_ready", 32'(cpu_ready), 32'd0);
        checkOutput("full_we",    32'(mem_we),    32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, '0, 0, 0, '0, '0, 0);
            @(negedge clk);
            checkOutput("drain_addr", 32'(mem_addr), 32'h20 + 32'(i));
        end
        applyStimulus(0, '0, 0, 0, '0, '0, 0);
        @(negedge clk);
        checkOutput("drain_ready", 32'(cpu_ready), 32'd1);

        // Read after buffered writes
        applyStimulus(1, '0, 1, 1, 20'h00011, 8'h5A, 0);
        applyStimulus(1, '0, 1, 1, 20'h00010, 8'h3C, 0);
        applyStimulus(0, '0, 1, 0, 20'h00010, '0, 0);
        waitRead("raw_rdata", 8'h3C);

        // Read held off by scanout for 10 cycles
        applyStimulus(1, '0, 0, 0, '0, '0, 1);
        applyStimulus(1, '0, 1, 0, 20'h00011, '0, 0);
        repeat (10) applyStimulus(1, '0, 0, 0, '0, '0, 0);
        applyStimulus(0, '0, 0, 0, '0, '0, 0);
        @(negedge clk);
        checkOutput("stall_issue_addr", 32'(mem_addr), 32'h11);
`ifdef VRAM_ARB_STATS_EN
        checkOutput("stall_cnt10", 32'(stall_cnt), 32'd10);
`endif
        waitRead("stall_rdata", 8'h5A);
`ifdef VRAM_ARB_STATS_EN
        applyStimulus(0, '0, 0, 0, '0, '0, 1);
        applyStimulus(0, '0, 0, 0, '0, '0, 0);
        @(negedge clk);
        checkOutput("stall_clr", 32'(stall_cnt), 32'd0);
`endif

        // Reset with three writes buffered and a read pending
        for (int i = 0; i < 3; i++) applyStimulus(1, '0, 1, 1, 20'(32'h40 + i), 8'(8'h70 + i), 0);
        applyStimulus(1, '0, 1, 0, 20'h00041, '0, 0);
        applyStimulus(1, '0, 0, 0, '0, '0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1; vga_en = 1'b0; cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(cpu_ready), 32'd1);
        checkOutput("post_rst_we",    32'(mem_we),    32'd0);
        repeat (6) applyStimulus(0, '0, 0, 0, '0, '0, 0);

        // Randomized traffic with scanout in bursts
        enState = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 11) == 0) enState = !enState;
            applyStimulus(enState, 20'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0), 20'($urandom_range(0, 31)), 8'($urandom),
                          ($urandom_range(0, 63) == 0));
        end
        applyStimulus(0, '0, 0, 0, '0, '0, 0);
        repeat (12) applyStimulus(0, '0, 0, 0, '0, '0, 0);
        @(negedge clk);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
